// File: rtl/datamem_arb_pkg.sv
// Shared types and sizes for the four-master data-memory arbiter.
// The optional access timeout is enabled by defining DATAMEM_ARB_TIMEOUT_EN.
package datamem_arb_pkg;

   localparam int NUM_MASTERS = 4;
   localparam int ADDR_W      = 30;
   localparam int DATA_W      = 32;
   localparam int BE_W        = 4;
   localparam int IDX_W       = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   typedef struct packed {
      logic              read;
      logic [BE_W-1:0]   we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;

   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
      onehot_to_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (oh[i]) onehot_to_idx = IDX_W'(i);
      end
   endfunction

endpackage

// File: rtl/datamem_arbiter_if.sv
// Master-side request/response buses and the single memory-side port.
// The arbiter connects through the slave modport, the environment through master.
interface datamem_arbiter_if;
   import datamem_arb_pkg::*;

   logic [NUM_MASTERS-1:0]        M_DataMem_Read;
   logic [NUM_MASTERS*BE_W-1:0]   M_DataMem_Write;
   logic [NUM_MASTERS*ADDR_W-1:0] M_DataMem_Address;
   logic [NUM_MASTERS*DATA_W-1:0] M_DataMem_Out;
   logic [DATA_W-1:0]             M_DataMem_In;
   logic [NUM_MASTERS-1:0]        M_DataMem_Ready;

   logic                          Mem_DataMem_Read;
   logic [BE_W-1:0]               Mem_DataMem_Write;
   logic [ADDR_W-1:0]             Mem_DataMem_Address;
   logic [DATA_W-1:0]             Mem_DataMem_Out;
   logic [DATA_W-1:0]             Mem_DataMem_In;
   logic                          Mem_DataMem_Ready;

   modport slave (
      input  M_DataMem_Read, M_DataMem_Write, M_DataMem_Address, M_DataMem_Out,
             Mem_DataMem_In, Mem_DataMem_Ready,
      output M_DataMem_In, M_DataMem_Ready,
             Mem_DataMem_Read, Mem_DataMem_Write, Mem_DataMem_Address, Mem_DataMem_Out
   );

   modport master (
      output M_DataMem_Read, M_DataMem_Write, M_DataMem_Address, M_DataMem_Out,
             Mem_DataMem_In, Mem_DataMem_Ready,
      input  M_DataMem_In, M_DataMem_Ready,
             Mem_DataMem_Read, Mem_DataMem_Write, Mem_DataMem_Address, Mem_DataMem_Out
   );

endinterface

// File: rtl/datamem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after the pointer,
// scanning upward modulo NUM_MASTERS.
module rr_picker
   import datamem_arb_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [IDX_W-1:0]       ptr_i,
   output logic [NUM_MASTERS-1:0] winner_o,
   output logic                   valid_o
);

   logic [IDX_W-1:0] idx;
   logic             found;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      winner_o = '0;
      found    = 1'b0;
      idx      = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         idx = ptr_i + IDX_W'(i);
         if (req_i[idx] && !found) begin
            winner_o[idx] = 1'b1;
            found         = 1'b1;
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing one data memory between four masters.
// Define DATAMEM_ARB_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES for Ready.
module datamem_arbiter
   import datamem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                   clock,
   input  logic                   reset,
   datamem_arbiter_if.slave       bus,
   output logic [NUM_MASTERS-1:0] Arb_Grant,
   output logic                   Arb_Timeout
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("datamem_arbiter: TIMEOUT_CYCLES must be within 1..65535");
   end

   state_e                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   cmd_t                   cmd_q, cmd_d;

   logic [NUM_MASTERS-1:0] req;
   cmd_t                   req_cmd [NUM_MASTERS];
   logic [NUM_MASTERS-1:0] pick_winner;
   logic                   pick_valid;
   logic                   expire;
   logic                   done;

   // A master asserting Read and byte enables together is latched as a write.
   for (genvar n = 0; n < NUM_MASTERS; n++) begin : g_req
      logic [BE_W-1:0] be;
      assign be         = bus.M_DataMem_Write[n*BE_W +: BE_W];
      assign req[n]     = bus.M_DataMem_Read[n] | (|be);
      assign req_cmd[n] = '{read: bus.M_DataMem_Read[n] & ~(|be),
                            we:   be,
                            addr: bus.M_DataMem_Address[n*ADDR_W +: ADDR_W],
                            data: bus.M_DataMem_Out[n*DATA_W +: DATA_W]};
   end

   rr_picker u_picker (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .winner_o (pick_winner),
      .valid_o  (pick_valid)
   );

`ifdef DATAMEM_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] cnt_q, cnt_d;

   assign expire = (state_q == ACCESS) && !bus.Mem_DataMem_Ready && (cnt_q == TO_LAST);
   assign cnt_d  = (state_q == ACCESS) ? cnt_q + 16'd1 : '0;

   always_ff @(posedge clock) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign Arb_Timeout = expire & ~reset;
`else
   assign expire      = 1'b0;
   assign Arb_Timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cmd_d   = cmd_q;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = ACCESS;
               grant_d = pick_winner;
               cmd_d   = req_cmd[onehot_to_idx(pick_winner)];
            end
         end
         ACCESS: begin
            done = bus.Mem_DataMem_Ready | expire;
            if (done) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = onehot_to_idx(grant_q) + IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cmd_q   <= cmd_d;
      end
   end

   // Ready is a combinational pass-through; a concurrent reset suppresses it.
   assign bus.M_DataMem_Ready     = (done && !reset) ? grant_q : '0;
   assign bus.M_DataMem_In        = bus.Mem_DataMem_In;
   assign bus.Mem_DataMem_Read    = (state_q == ACCESS) & cmd_q.read;
   assign bus.Mem_DataMem_Write   = (state_q == ACCESS) ? cmd_q.we : '0;
   assign bus.Mem_DataMem_Address = cmd_q.addr;
   assign bus.Mem_DataMem_Out     = cmd_q.data;
   assign Arb_Grant               = grant_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared
// cycle by cycle against a transaction-level model of the arbitration rules.
module tb_datamem_arbiter;

`ifdef DATAMEM_ARB_TIMEOUT_EN
   localparam int TO    = 4;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO    = 255;
   localparam bit TO_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] arb_grant;
   logic       arb_timeout;

   datamem_arbiter_if bus ();

   datamem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus.slave),
      .Arb_Grant   (arb_grant),
      .Arb_Timeout (arb_timeout)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: is an access in flight, who owns it, what was latched, how long it has waited.
   bit          m_busy;
   int          m_owner;
   int          m_ptr;
   int          m_waited;
   bit          m_read;
   logic [3:0]  m_we;
   logic [29:0] m_addr;
   logic [31:0] m_data;
   bit          m_done;

   int          dut_grants[$];
   logic [3:0]  prev_grant;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic bit requests(input int n);
      return bus.M_DataMem_Read[n] || (bus.M_DataMem_Write[4*n +: 4] != 4'b0);
   endfunction

   function automatic int idx_of(input logic [3:0] oh);
      for (int i = 0; i < 4; i++) if (oh[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_ptr = 0; m_waited = 0;
      m_read = 0; m_we = '0; m_addr = '0; m_data = '0;
   endtask

   // Settle after the inputs were driven, then compare every output to the model.
   task automatic eval();
      bit timed_out;
      #1;
      timed_out = m_busy && !reset && !bus.Mem_DataMem_Ready && TO_EN && (m_waited == TO - 1);
      m_done    = m_busy && !reset && (bus.Mem_DataMem_Ready || timed_out);
      check("grant",      arb_grant,                m_busy ? (4'b1 << m_owner) : 4'b0);
      check("timeout",    arb_timeout,              timed_out);
      check("m_ready",    bus.M_DataMem_Ready,      m_done ? (4'b1 << m_owner) : 4'b0);
      check("m_in",       bus.M_DataMem_In,         bus.Mem_DataMem_In);
      check("mem_read",   bus.Mem_DataMem_Read,     m_busy && m_read);
      check("mem_write",  bus.Mem_DataMem_Write,    m_busy ? m_we : 4'b0);
      check("mem_addr",   bus.Mem_DataMem_Address,  m_addr);
      check("mem_out",    bus.Mem_DataMem_Out,      m_data);
      if (arb_grant != 4'b0 && prev_grant == 4'b0) dut_grants.push_back(idx_of(arb_grant));
      prev_grant = arb_grant;
   endtask

   // Apply the clock edge to the model, then move to the next negative edge.
   task automatic adv();
      if (reset) begin
         model_reset();
      end else if (m_busy) begin
         if (m_done) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % 4;
         end else begin
            m_waited++;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            int n;
            n = (m_ptr + i) % 4;
            if (!m_busy && requests(n)) begin
               m_busy   = 1;
               m_owner  = n;
               m_waited = 0;
               m_we     = bus.M_DataMem_Write[4*n +: 4];
               m_read   = bus.M_DataMem_Read[n] && (m_we == 4'b0);
               m_addr   = bus.M_DataMem_Address[30*n +: 30];
               m_data   = bus.M_DataMem_Out[32*n +: 32];
            end
         end
      end
      @(negedge clock);
   endtask

   task automatic quiet();
      bus.M_DataMem_Read    = '0;
      bus.M_DataMem_Write   = '0;
      bus.Mem_DataMem_Ready = 1'b0;
   endtask

   task automatic randomize_inputs();
      logic [31:0] r;
      for (int n = 0; n < 4; n++) begin
         r = $urandom();
         bus.M_DataMem_Address[30*n +: 30] = r[29:0];
         bus.M_DataMem_Out[32*n +: 32]     = $urandom();
         r = $urandom();
         bus.M_DataMem_Read[n]             = (r[1:0] == 2'b00);
         bus.M_DataMem_Write[4*n +: 4]     = (r[3:2] == 2'b00) ? r[7:4] : 4'b0;
      end
      bus.Mem_DataMem_In    = $urandom();
      bus.Mem_DataMem_Ready = ($urandom_range(0, 2) == 0);
      reset                 = ($urandom_range(0, 63) == 0);
   endtask

   initial begin
      reset      = 1'b1;
      prev_grant = '0;
      bus.M_DataMem_Address = '0;
      bus.M_DataMem_Out     = '0;
      bus.Mem_DataMem_In    = 32'hdead_beef;
      quiet();
      model_reset();
      repeat (2) @(negedge clock);

      // Reset state, with Ready asserted and requests present.
      bus.M_DataMem_Read    = 4'b1111;
      bus.Mem_DataMem_Ready = 1'b1;
      eval(); adv();

      // All four request continuously, memory always ready.
      reset = 1'b0;
      dut_grants.delete();
      repeat (10) begin eval(); adv(); end
      check("rr_count", dut_grants.size(), 5);
      for (int i = 0; i < 5 && i < dut_grants.size(); i++)
         check($sformatf("rr_order%0d", i), dut_grants[i], i % 4);
      quiet();
      eval(); adv();

      // Master 2 reads 0x10 alone; Ready one cycle later.
      bus.M_DataMem_Read[2]             = 1'b1;
      bus.M_DataMem_Address[60 +: 30]   = 30'h10;
      eval(); adv();
      bus.Mem_DataMem_Ready = 1'b1;
      bus.Mem_DataMem_In    = 32'h1234_5678;
      eval();
      check("m2_grant",  arb_grant,               4'b0100);
      check("m2_ready",  bus.M_DataMem_Ready,     4'b0100);
      check("m2_data",   bus.M_DataMem_In,        32'h1234_5678);
      check("m2_addr",   bus.Mem_DataMem_Address, 30'h10);
      adv();
      quiet();
      eval(); adv();

      // Master 1 writes BE=0011, then moves its address while the access waits.
      bus.M_DataMem_Write[4 +: 4]     = 4'b0011;
      bus.M_DataMem_Read[1]           = 1'b1;
      bus.M_DataMem_Address[30 +: 30] = 30'h0abc_def0;
      bus.M_DataMem_Out[32 +: 32]     = 32'hcafe_f00d;
      eval(); adv();
      bus.M_DataMem_Address[30 +: 30] = 30'h0111_2222;
      bus.M_DataMem_Write[4 +: 4]     = 4'b1100;
      repeat (3) begin
         eval();
         check("hold_addr", bus.Mem_DataMem_Address, 30'h0abc_def0);
         check("hold_be",   bus.Mem_DataMem_Write,   4'b0011);
         check("wr_no_rd",  bus.Mem_DataMem_Read,    1'b0);
         adv();
      end
      quiet();
      bus.Mem_DataMem_Ready = 1'b1;
      eval(); adv();
      bus.Mem_DataMem_Ready = 1'b0;
      eval(); adv();

      // Park the pointer on master 3, then reset mid-access together with Ready.
      bus.M_DataMem_Read[3] = 1'b1;
      eval(); adv();
      bus.M_DataMem_Read    = 4'b1111;
      bus.Mem_DataMem_Ready = 1'b1;
      reset                 = 1'b1;
      eval();
      check("rst_no_ready", bus.M_DataMem_Ready, 4'b0000);
      adv();
      reset                 = 1'b0;
      bus.Mem_DataMem_Ready = 1'b0;
      eval();
      check("rst_grant", arb_grant, 4'b0000);
      adv();
      eval();
      check("rst_next_m0", arb_grant, 4'b0001);
      adv();
      quiet();
      bus.Mem_DataMem_Ready = 1'b1;
      eval(); adv();
      quiet();

`ifdef DATAMEM_ARB_TIMEOUT_EN
      // Memory never answers: the access is aborted on its TO-th waiting cycle.
      begin
         int access_cycles;
         bit seen;
         access_cycles = 0;
         seen          = 0;
         eval(); adv();
         bus.M_DataMem_Read = 4'b0110;
         for (int c = 0; c < 12; c++) begin
            eval();
            if (arb_grant != 4'b0 && !seen) access_cycles++;
            if (arb_timeout && !seen) begin
               seen = 1;
               check("to_cycles", access_cycles, TO);
               check("to_ready",  bus.M_DataMem_Ready, 4'b0010);
            end
            adv();
         end
         check("to_seen", seen, 1'b1);
         quiet();
      end
`endif

      // Random traffic with occasional resets.
      for (int c = 0; c < 1500; c++) begin
         randomize_inputs();
         eval(); adv();
      end
      reset = 1'b0;
      quiet();
      repeat (2) begin eval(); adv(); end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/datamem_arbiter.md
DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles an access waits for Mem_DataMem_Ready (range 1..65535).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 M_DataMem_Read  input  4  bit n = master n read request.
REQ-005 M_DataMem_Write  input  16  bits [4n+3:4n] = master n byte-write enables.
REQ-006 M_DataMem_Address  input  120  bits [30n+29:30n] = master n word address.
REQ-007 M_DataMem_Out  input  128  bits [32n+31:32n] = master n write data.
REQ-008 M_DataMem_In  output  32  memory read data, broadcast to all masters.
REQ-009 M_DataMem_Ready  output  4  bit n = completion pulse to master n.
REQ-010 Mem_DataMem_Read  output  1  read strobe to memory.
REQ-011 Mem_DataMem_Write  output  4  byte-write enables to memory.
REQ-012 Mem_DataMem_Address  output  30  word address to memory.
REQ-013 Mem_DataMem_Out  output  32  write data to memory.
REQ-014 Mem_DataMem_In  input  32  read data from memory.
REQ-015 Mem_DataMem_Ready  input  1  memory completion.
REQ-016 Arb_Grant  output  4  one-hot registered grant; 0 when idle.
REQ-017 Arb_Timeout  output  1  one-cycle pulse on aborted access.

Function
REQ-018 Master n requests when Read[n]=1 or any Write[4n+3:4n] bit is 1; Read and Write together from one master are treated as a write (Read forced 0 in latched command).
REQ-019 FSM states IDLE and ACCESS; IDLE->ACCESS when any request is present; ACCESS->IDLE on Mem_DataMem_Ready=1 (or timeout, REQ-026).
REQ-020 In IDLE, the winner is the first requester at or after round-robin pointer P (order P, P+1, ... mod 4); on the IDLE->ACCESS edge, Arb_Grant, the winner's command (Read, Write, Address, Out) are registered.
REQ-021 Latency: request sampled in cycle k; memory sees command from cycle k+1; ready pulse in the same cycle Mem_DataMem_Ready is seen (combinational pass-through).
REQ-022 In ACCESS, Mem_DataMem_* outputs drive the latched command and are stable; master input changes are ignored until return to IDLE.
REQ-023 M_DataMem_Ready[g] = Mem_DataMem_Ready while in ACCESS and Arb_Grant[g]=1; all other bits 0; Mem_DataMem_Ready in IDLE is ignored.
REQ-024 On completion, P <= g+1 mod 4; state returns to IDLE for exactly one cycle before the next grant (one-cycle bubble).
REQ-025 In IDLE, Mem_DataMem_Read=0, Mem_DataMem_Write=0, Address/Out hold last value; M_DataMem_In = Mem_DataMem_In always.

Reset
REQ-026 On reset=1 at a clock edge: state IDLE, P=0, Arb_Grant=0, latched command=0, timeout counter=0, Arb_Timeout=0; an in-flight access is abandoned with no ready pulse.
REQ-027 Reset has priority over every other event in the same cycle, including Mem_DataMem_Ready.

Configuration
REQ-028 Macro DATAMEM_ARB_TIMEOUT_EN: when defined, a counter clears on entering ACCESS, increments each ACCESS cycle without Ready; on reaching TIMEOUT_CYCLES, FSM returns to IDLE, Arb_Timeout pulses 1 cycle, M_DataMem_Ready[g] pulses 1, P advances as REQ-024.
REQ-029 Ready arriving in the same cycle the count reaches TIMEOUT_CYCLES completes normally; Arb_Timeout stays 0.
REQ-030 Without the macro: no counter is synthesized, Arb_Timeout is constant 0, ACCESS waits indefinitely.

Structure
REQ-031 Package datamem_arb_pkg holds state encoding (IDLE, ACCESS), NUM_MASTERS=4, ADDR_W=30, DATA_W=32, BE_W=4.
REQ-032 Sub-module rr_picker (combinational): inputs 4-bit request and 2-bit pointer, outputs one-hot winner and valid.

Verification
REQ-033 Master 2 reads 0x00000010 alone, Ready one cycle later with In=0x12345678 -> Arb_Grant=0100, M ready[2] pulses, M_DataMem_In=0x12345678.
REQ-034 All four request continuously from reset, Ready returns after 1 cycle each -> grants in order 0,1,2,3,0 with one idle cycle between.
REQ-035 Master 1 writes BE=0011 then changes Address mid-access -> Mem_DataMem_Address keeps the original value until Ready.
REQ-036 reset asserted in ACCESS same cycle as Ready -> no M ready pulse, Arb_Grant=0, next grant goes to master 0.
REQ-037 DATAMEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, Ready never asserted -> Arb_Timeout and M ready[g] pulse 4 cycles after grant, next requester granted.
